// File: rtl/ntt_pkg.sv
// Shared NTT constants and helpers: default data width, modulus Q,
// K = clog2(Q) and the Barrett constant MU = floor(2^(2K)/Q).
package ntt_pkg;

  localparam int unsigned DATA_WIDTH = 18;

  function automatic int unsigned clog2(input longint unsigned v);
    int unsigned r;
    longint unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic longint unsigned barrett_mu(input longint unsigned q);
    int unsigned k;
    k = clog2(q);
    return (64'd1 << (2 * k)) / q;
  endfunction

  localparam int unsigned Q  = 12289;
  localparam int unsigned K  = clog2(Q);
  localparam longint unsigned MU = barrett_mu(Q);

endpackage

// File: rtl/barrett_reduce.sv
// Barrett reduction of a 2K-bit product modulo Q over two stall-gated stages
// (quotient estimate, then subtract and up to two conditional corrections).
module barrett_reduce
  import ntt_pkg::*;
#(
  parameter  int unsigned Q  = ntt_pkg::Q,
  localparam int unsigned KB = clog2(Q)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [2*KB-1:0] p,
  input  logic            zero,
  output logic [KB-1:0]   t
);

  localparam logic [KB:0]   MU_V = (KB+1)'(barrett_mu(Q));
  localparam logic [KB+1:0] Q_R  = (KB+2)'(Q);

  logic [2*KB-1:0] p3;
  logic [KB:0]     qh3;
  logic            z3;
  logic [2*KB+1:0] qh_prod;
  logic [KB:0]     qh_next;
  logic [KB+1:0]   r0, r1, r2;

  always_comb begin
    qh_prod = (2*KB+2)'(p[2*KB-1:KB-1]) * (2*KB+2)'(MU_V);
    qh_next = (KB+1)'(qh_prod >> (KB+1));
  end

  // The estimate is at most 2 below the true quotient, so r < 3Q fits in K+2 bits.
  always_comb begin
    r0 = (KB+2)'((2*KB+2)'(p3) - (2*KB+2)'(qh3) * (2*KB+2)'(Q));
    r1 = (r0 >= Q_R) ? r0 - Q_R : r0;
    r2 = (r1 >= Q_R) ? r1 - Q_R : r1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p3  <= '0;
      qh3 <= '0;
      z3  <= 1'b0;
      t   <= '0;
    end else if (en) begin
      p3  <= p;
      qh3 <= qh_next;
      z3  <= zero;
      t   <= z3 ? '0 : KB'(r2);
    end
  end

endmodule

// File: rtl/mod_mult_pipe.sv
// Pipelined (b*w) mod Q with valid/ready handshake and tag passthrough.
// Define MODMUL_RANGE_CHECK_EN to flag operands >= Q (sticky err_range, result zeroed).
module mod_mult_pipe
  import ntt_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH,
  parameter int unsigned Q     = ntt_pkg::Q,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_w,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_t,
  output logic [TAG_W-1:0] out_tag,
  output logic             err_range
);

  localparam int unsigned KW = clog2(Q);

  logic             stall;
  logic [3:0]       vld;
  logic [TAG_W-1:0] tag_sr [4];
  logic [KW-1:0]    b1, w1;
  logic [2*KW-1:0]  p2;
  logic             zero2;
  logic [KW-1:0]    t_k;

  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = vld[3];
  assign out_tag   = tag_sr[3];
  assign out_t     = WIDTH'(t_k);

  // Rigid shift register: while unstalled in_ready=1, so in_valid is the transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int unsigned i = 0; i < 4; i++) tag_sr[i] <= '0;
      b1  <= '0;
      w1  <= '0;
      p2  <= '0;
    end else if (!stall) begin
      vld       <= {vld[2:0], in_valid};
      tag_sr[0] <= in_tag;
      for (int unsigned i = 1; i < 4; i++) tag_sr[i] <= tag_sr[i-1];
      b1        <= in_b[KW-1:0];
      w1        <= in_w[KW-1:0];
      p2        <= (2*KW)'(b1) * (2*KW)'(w1);
    end
  end

  barrett_reduce #(.Q(Q)) u_barrett (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!stall),
    .p     (p2),
    .zero  (zero2),
    .t     (t_k)
  );

`ifdef MODMUL_RANGE_CHECK_EN
  localparam logic [WIDTH-1:0] Q_W = WIDTH'(Q);

  logic bad_in, bad1, bad2, err_q;

  assign bad_in = (in_b >= Q_W) || (in_w >= Q_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad1  <= 1'b0;
      bad2  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (!stall) begin
        bad1 <= in_valid && bad_in;
        bad2 <= bad1;
      end
      if (in_valid && !stall && bad_in) err_q <= 1'b1;
    end
  end

  assign zero2     = bad2;
  assign err_range = err_q;
`else
  logic unused_hi;
  assign unused_hi = ^{in_b[WIDTH-1:KW], in_w[WIDTH-1:KW]};
  assign zero2     = 1'b0;
  assign err_range = 1'b0;
`endif

endmodule

// File: tb/tb_mod_mult_pipe.sv
// Randomized self-checking bench for mod_mult_pipe against a queue-based
// (b*w)%Q reference model with in-order tag tracking.
module tb_mod_mult_pipe;

  localparam int unsigned WIDTH = 18;
  localparam int unsigned TAG_W = 8;
  localparam int          QM    = 12289;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_b = '0;
  logic [WIDTH-1:0] in_w = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_t;
  logic [TAG_W-1:0] out_tag;
  logic             err_range;

  mod_mult_pipe #(.WIDTH(WIDTH), .Q(QM), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_b      (in_b),
    .in_w      (in_w),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_t     (out_t),
    .out_tag   (out_tag),
    .err_range (err_range)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int src_b[$], src_w[$], src_tag[$];
  int exp_t[$], exp_tag[$];
  int fire_cyc[$], out_seen[$];
  int cyc = 0;
  bit last_in_fire = 0;
  bit held_prev = 0;
  bit err_exp = 0;
  logic [WIDTH-1:0] held_t;
  logic [TAG_W-1:0] held_tag;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // -1 marks a don't-care result (out-of-range operands without range checking).
  function automatic int ref_t(input int b, input int w);
    if (b >= QM || w >= QM) begin
`ifdef MODMUL_RANGE_CHECK_EN
      return 0;
`else
      return -1;
`endif
    end
    return int'((longint'(b) * longint'(w)) % longint'(QM));
  endfunction

  task automatic push_beat(input int b, input int w, input int tag);
    src_b.push_back(b);
    src_w.push_back(w);
    src_tag.push_back(tag);
  endtask

  task automatic run_cycle(input bit offer, input bit oready);
    int t, tg;
    @(negedge clk);
    cyc++;
    if (!(in_valid && !last_in_fire)) begin
      if (offer && src_b.size() > 0) begin
        in_valid = 1'b1;
        in_b     = WIDTH'(src_b.pop_front());
        in_w     = WIDTH'(src_w.pop_front());
        in_tag   = TAG_W'(src_tag.pop_front());
      end else begin
        in_valid = 1'b0;
      end
    end
    out_ready = oready;
    #1;
    if (held_prev) begin
      check_eq("hold_t", out_t, held_t);
      check_eq("hold_tag", out_tag, held_tag);
    end
    check_eq("in_ready", in_ready, !(out_valid && !out_ready));
    check_eq("err_range", err_range, err_exp);
    if (out_valid && out_ready) begin
      if (exp_t.size() == 0) begin
        check_eq("spurious_out", out_valid, 0);
      end else begin
        t  = exp_t.pop_front();
        tg = exp_tag.pop_front();
        if (t >= 0) check_eq("out_t", out_t, t);
        check_eq("out_tag", out_tag, tg);
        fire_cyc.push_back(cyc);
        out_seen.push_back(int'(out_t));
      end
    end
    held_prev    = out_valid && !out_ready;
    held_t       = out_t;
    held_tag     = out_tag;
    last_in_fire = in_valid && in_ready;
    if (last_in_fire) begin
      exp_t.push_back(ref_t(int'(in_b), int'(in_w)));
      exp_tag.push_back(int'(in_tag));
`ifdef MODMUL_RANGE_CHECK_EN
      if (int'(in_b) >= QM || int'(in_w) >= QM) err_exp = 1;
`endif
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((src_b.size() > 0 || exp_t.size() > 0 || (in_valid && !last_in_fire)) && n < budget) begin
      run_cycle(1'b1, 1'b1);
      n++;
    end
    check_eq("drain_pending", src_b.size() + exp_t.size(), 0);
  endtask

  initial begin
    int c0, n;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_t", out_t, 0);
    check_eq("rst_out_tag", out_tag, 0);
    check_eq("rst_err_range", err_range, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 1);

    // Single beat: latency and value
    fire_cyc.delete();
    out_seen.delete();
    push_beat(1234, 5678, 8'h5A);
    run_cycle(1'b1, 1'b1);
    c0 = cyc;
    check_eq("single_accept", last_in_fire, 1);
    drain(20);
    check_eq("single_count", out_seen.size(), 1);
    if (out_seen.size() >= 1) begin
      check_eq("single_latency", fire_cyc[0] - c0, 4);
      check_eq("single_t", out_seen[0], 1922);
    end

    // Boundary operands, back to back
    fire_cyc.delete();
    out_seen.delete();
    push_beat(12288, 12288, 8'h01);
    push_beat(0, 7777, 8'h02);
    push_beat(2, 3, 8'h03);
    drain(30);
    check_eq("bnd_count", out_seen.size(), 3);
    if (out_seen.size() >= 3) begin
      check_eq("bnd_t0", out_seen[0], 1);
      check_eq("bnd_t1", out_seen[1], 0);
      check_eq("bnd_t2", out_seen[2], 6);
      check_eq("bnd_consecutive", fire_cyc[2] - fire_cyc[0], 2);
    end

    // Back-pressure: out_ready low for 5 cycles mid-stream
    out_seen.delete();
    for (int i = 0; i < 10; i++)
      push_beat(int'($urandom_range(0, QM - 1)), int'($urandom_range(0, QM - 1)), 8'h10 + i);
    for (int i = 0; i < 16; i++) run_cycle(1'b1, !(i >= 5 && i < 10));
    drain(40);
    check_eq("bp_count", out_seen.size(), 10);

    // Reset with 3 beats in flight, output stalled
    for (int i = 0; i < 3; i++) push_beat(100 + i, 200 + i, 8'hA0 + i);
    for (int i = 0; i < 5; i++) run_cycle(1'b1, 1'b0);
    check_eq("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_out_t", out_t, 0);
    exp_t.delete();
    exp_tag.delete();
    src_b.delete();
    src_w.delete();
    src_tag.delete();
    in_valid = 1'b0;
    last_in_fire = 0;
    held_prev = 0;
    err_exp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_seen.delete();
    push_beat(11, 13, 8'hC1);
    push_beat(4000, 5000, 8'hC2);
    drain(30);
    check_eq("postrst_count", out_seen.size(), 2);

    // Random regression
    out_seen.delete();
    for (int i = 0; i < 10000; i++)
      push_beat(int'($urandom_range(0, QM - 1)), int'($urandom_range(0, QM - 1)),
                int'($urandom_range(0, 255)));
    n = 0;
    while ((src_b.size() > 0 || exp_t.size() > 0 || (in_valid && !last_in_fire)) && n < 60000) begin
      run_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
      n++;
    end
    check_eq("rand_pending", src_b.size() + exp_t.size(), 0);
    check_eq("rand_count", out_seen.size(), 10000);

    // Out-of-range operand
    push_beat(12289, 5, 8'h77);
    drain(20);
`ifdef MODMUL_RANGE_CHECK_EN
    check_eq("range_err_final", err_range, 1);
`else
    check_eq("range_err_final", err_range, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
